// File: rtl/duty_ramp_ctrl.sv
// Duty-cycle slew limiter: ramps duty toward a latched target, one step per STEP_DIV clocks.
// Optional DUTY_RAMP_BYPASS_EN adds a bypass input that jumps duty straight to the target.
module duty_ramp_ctrl #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int STEP_HZ  = 100,
   parameter int DUTY_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] target,
   input  logic              load,
   input  logic              enable,
`ifdef DUTY_RAMP_BYPASS_EN
   input  logic              bypass,
`endif
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              done,
   output logic              at_max,
   output logic              at_min
);

   localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
   localparam int CW       = $clog2(STEP_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   state_t            state, state_n;
   logic [DUTY_W-1:0] tgt_q, tgt_n, duty_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              done_n, busy_n;
   logic              byp_q, byp_n;
   logic              byp_req;
   logic              tick;

`ifdef DUTY_RAMP_BYPASS_EN
   assign byp_req = load & bypass;
`else
   assign byp_req = 1'b0;
`endif

   assign tick   = (state != IDLE) && enable && (cnt == CNT_LAST);
   assign at_max = (duty == {DUTY_W{1'b1}});
   assign at_min = (duty == '0);

   always_comb begin
      state_n = state;
      duty_n  = duty;
      tgt_n   = tgt_q;
      cnt_n   = cnt;
      done_n  = byp_q;
      byp_n   = 1'b0;
      if (byp_req) begin
         // bypass jump: done trails the new duty by one cycle
         duty_n  = target;
         tgt_n   = target;
         cnt_n   = '0;
         state_n = IDLE;
         byp_n   = 1'b1;
      end else if (load) begin
         tgt_n = target;
         cnt_n = '0;
         if (target > duty) begin
            state_n = UP;
         end else if (target < duty) begin
            state_n = DOWN;
         end else begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
      end else begin
         unique case (state)
            IDLE: cnt_n = '0;
            UP: begin
               if (enable) cnt_n = tick ? '0 : cnt + 1'b1;
               if (tick) begin
                  duty_n = duty + 1'b1;
                  if (duty_n == tgt_q) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            DOWN: begin
               if (enable) cnt_n = tick ? '0 : cnt + 1'b1;
               if (tick) begin
                  duty_n = duty - 1'b1;
                  if (duty_n == tgt_q) begin
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         duty  <= '0;
         tgt_q <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         byp_q <= 1'b0;
      end else begin
         state <= state_n;
         duty  <= duty_n;
         tgt_q <= tgt_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         byp_q <= byp_n;
      end
   end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Bench for duty_ramp_ctrl: directed vector table, bypass sequence, random run vs model.
// Exercises the DUTY_RAMP_BYPASS_EN port when that macro is defined.
module tb_duty_ramp_ctrl;

   localparam int CF = 40;
   localparam int SH = 10;
   localparam int DW = 4;
   localparam int SD = CF / SH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic          enable = 1'b1;
   logic          bypass = 1'b0;
   logic [DW-1:0] target = '0;
   logic [DW-1:0] duty;
   logic          busy, done, at_max, at_min;

   duty_ramp_ctrl #(.CLK_FREQ(CF), .STEP_HZ(SH), .DUTY_W(DW)) dut (
      .clk(clk),
      .rst(rst),
      .target(target),
      .load(load),
      .enable(enable),
`ifdef DUTY_RAMP_BYPASS_EN
      .bypass(bypass),
`endif
      .duty(duty),
      .busy(busy),
      .done(done),
      .at_max(at_max),
      .at_min(at_min)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   // behavioural reference: position, goal, enabled cycles since last step
   int m_duty = 0, m_tgt = 0, m_ph = 0;
   bit m_busy = 0, m_done = 0, m_pend = 0;

   task automatic model_upd();
      if (rst) begin
         m_duty = 0; m_tgt = 0; m_ph = 0;
         m_busy = 0; m_done = 0; m_pend = 0;
      end else begin
         m_done = m_pend;
         m_pend = 0;
         if (load) begin
            m_tgt = int'(target);
            m_ph  = 0;
            if (bypass) begin
               m_duty = int'(target);
               m_busy = 0;
               m_pend = 1;
            end else begin
               m_busy = (m_tgt != m_duty);
               if (!m_busy) m_done = 1;
            end
         end else if (m_busy && enable) begin
            m_ph++;
            if (m_ph == SD) begin
               m_ph = 0;
               m_duty += (m_tgt > m_duty) ? 1 : -1;
               if (m_duty == m_tgt) begin
                  m_busy = 0;
                  m_done = 1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got {duty,busy,done,max,min}=%h expected %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] outs();
      return {duty, busy, done, at_max, at_min};
   endfunction

   task automatic cyc();
      logic [3:0] md;
      @(posedge clk);
      model_upd();
      #1;
      md = 4'(m_duty);
      chk("model", outs(), {md, m_busy, m_done, md == 4'hf, md == 4'h0});
   endtask

   typedef struct {
      bit         r;
      bit         ld;
      bit         en;
      logic [3:0] t;
      int         n;
      logic [3:0] d;
      bit         b;
      bit         dn;
   } vec_t;

   vec_t tv [34];

   initial begin
      tv[0]  = '{1, 0, 1, 4'd0,  1,  4'd0,  0, 0};
      tv[1]  = '{0, 1, 1, 4'd3,  1,  4'd0,  1, 0};
      tv[2]  = '{0, 0, 1, 4'd0,  4,  4'd1,  1, 0};
      tv[3]  = '{0, 0, 1, 4'd0,  4,  4'd2,  1, 0};
      tv[4]  = '{0, 0, 1, 4'd0,  3,  4'd2,  1, 0};
      tv[5]  = '{0, 0, 1, 4'd0,  1,  4'd3,  0, 1};
      tv[6]  = '{0, 0, 1, 4'd0,  1,  4'd3,  0, 0};
      tv[7]  = '{0, 1, 1, 4'd15, 1,  4'd3,  1, 0};
      tv[8]  = '{0, 0, 1, 4'd0,  47, 4'd14, 1, 0};
      tv[9]  = '{0, 0, 1, 4'd0,  1,  4'd15, 0, 1};
      tv[10] = '{0, 0, 1, 4'd0,  10, 4'd15, 0, 0};
      tv[11] = '{1, 0, 1, 4'd0,  1,  4'd0,  0, 0};
      tv[12] = '{0, 1, 1, 4'd12, 1,  4'd0,  1, 0};
      tv[13] = '{0, 0, 1, 4'd0,  32, 4'd8,  1, 0};
      tv[14] = '{0, 1, 1, 4'd5,  1,  4'd8,  1, 0};
      tv[15] = '{0, 0, 1, 4'd0,  4,  4'd7,  1, 0};
      tv[16] = '{0, 0, 1, 4'd0,  8,  4'd5,  0, 1};
      tv[17] = '{0, 0, 1, 4'd0,  1,  4'd5,  0, 0};
      tv[18] = '{0, 1, 1, 4'd10, 2,  4'd5,  1, 0};
      tv[19] = '{0, 0, 0, 4'd0,  20, 4'd5,  1, 0};
      tv[20] = '{0, 0, 1, 4'd0,  2,  4'd5,  1, 0};
      tv[21] = '{0, 0, 1, 4'd0,  1,  4'd6,  1, 0};
      tv[22] = '{0, 1, 1, 4'd6,  1,  4'd6,  0, 1};
      tv[23] = '{0, 0, 1, 4'd0,  1,  4'd6,  0, 0};
      tv[24] = '{0, 1, 1, 4'd9,  1,  4'd6,  1, 0};
      tv[25] = '{1, 0, 1, 4'd0,  1,  4'd0,  0, 0};
      tv[26] = '{0, 0, 1, 4'd0,  5,  4'd0,  0, 0};
      tv[27] = '{0, 1, 0, 4'd2,  1,  4'd0,  1, 0};
      tv[28] = '{0, 0, 0, 4'd0,  6,  4'd0,  1, 0};
      tv[29] = '{0, 0, 1, 4'd0,  4,  4'd1,  1, 0};
      tv[30] = '{0, 0, 1, 4'd0,  3,  4'd1,  1, 0};
      tv[31] = '{0, 1, 1, 4'd0,  1,  4'd1,  1, 0};
      tv[32] = '{0, 0, 1, 4'd0,  3,  4'd1,  1, 0};
      tv[33] = '{0, 0, 1, 4'd0,  1,  4'd0,  0, 1};

      // first reset cycle; tv[0] supplies the second
      cyc();

      for (int i = 0; i < 34; i++) begin
         rst    = tv[i].r;
         load   = tv[i].ld;
         enable = tv[i].en;
         target = tv[i].t;
         cyc();
         rst  = 1'b0;
         load = 1'b0;
         for (int k = 1; k < tv[i].n; k++) cyc();
         chk($sformatf("vec%0d", i), outs(),
             {tv[i].d, tv[i].b, tv[i].dn, tv[i].d == 4'hf, tv[i].d == 4'h0});
      end

`ifdef DUTY_RAMP_BYPASS_EN
      enable = 1'b1;
      bypass = 1'b1;
      load   = 1'b1;
      target = 4'd12;
      cyc();
      chk("byp_jump", outs(), {4'd12, 1'b0, 1'b0, 1'b0, 1'b0});
      bypass = 1'b0;
      load   = 1'b0;
      cyc();
      chk("byp_done", outs(), {4'd12, 1'b0, 1'b1, 1'b0, 1'b0});
      cyc();
      chk("byp_after", outs(), {4'd12, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

      for (int c = 0; c < 3000; c++) begin
         rst    = ($urandom % 300) == 0;
         load   = ($urandom % 12) == 0;
         enable = ($urandom % 5) != 0;
         target = 4'($urandom);
`ifdef DUTY_RAMP_BYPASS_EN
         bypass = ($urandom % 3) == 0;
`endif
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/duty_ramp_ctrl.md
Name: duty_ramp_ctrl

Overview:
Upstream stage of the PWM controller. Accepts a 4-bit target duty from switches or the ALU result and slews the live duty value toward that target at a fixed, parameterised step rate. Its duty output drives the PWM controller's duty input directly. Soft-starting avoids step changes on the driven load (motor/LED).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
STEP_HZ, 100, duty steps per second; STEP_DIV = CLK_FREQ/STEP_HZ clock cycles per step (integer; must be >= 2)
DUTY_W, 4, width of target/duty; duty range 0..2^DUTY_W-1

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
target  in  DUTY_W  requested duty; sampled only when load=1
load  in  1  single-cycle request to latch target and start ramping
enable  in  1  1 = ramp runs; 0 = freeze (duty held, prescaler held)
duty  out  DUTY_W  current duty, registered; feeds the PWM controller
busy  out  1  1 while state is UP or DOWN
done  out  1  one-cycle pulse when duty reaches the latched target
at_max  out  1  duty == 2^DUTY_W-1 (combinational from the duty register)
at_min  out  1  duty == 0 (combinational from the duty register)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high. rst wins over every other input.
- Reset values: duty=0, tgt_q=0, prescaler=0, state=IDLE, busy=0, done=0. at_min=1 and at_max=0 follow from duty.
- Prescaler:
  - Counts 0..STEP_DIV-1 while state is UP or DOWN and enable=1.
  - step_tick is asserted on the cycle the count equals STEP_DIV-1; the count then wraps to 0.
  - Held at its current value when enable=0. Forced to 0 in IDLE and on every accepted load.
- States: IDLE, UP, DOWN. busy is registered: it is 1 exactly when the next state is UP or DOWN.
- Load (accepted in any state, including mid-ramp):
  - tgt_q <= target; prescaler <= 0.
  - Next state: UP if target > duty; DOWN if target < duty; IDLE if equal.
  - Equal case: done=1 on the following cycle.
  - A load mid-ramp retargets immediately. duty keeps its current value; there is no jump.
- UP: on each step_tick, duty <= duty+1. If duty+1 == tgt_q, go to IDLE and assert done in the same cycle the final duty value appears.
- DOWN: mirror of UP, with duty-1.
- Latency: first step arrives STEP_DIV cycles after the cycle load is sampled. The full ramp from a to b takes |b-a|*STEP_DIV cycles.
- Saturation: duty never wraps. The UP/DOWN exit comparison guarantees this; no extra clamping is required. Ramp 0->15 ends at 15.
- load and step_tick in the same cycle: load has priority. The tick is discarded and duty is unchanged that cycle.
- enable=0 during load: load is still latched and the state is set, but no steps occur until enable=1.
- done is a registered pulse, exactly one cycle wide. It is never asserted in the same cycle as rst.
- IDLE with no load: all outputs hold.

Optional Feature:
DUTY_RAMP_BYPASS_EN
- Defined: adds input port "bypass" (1 bit). When load=1 and bypass=1:
  - duty <= target and tgt_q <= target on the next edge.
  - State goes to IDLE; done pulses on the following cycle.
  - When bypass=0, behaviour is unchanged.
- Not defined: no bypass port; all changes are ramped.

Test Plan:
CLK_FREQ=40, STEP_HZ=10 (STEP_DIV=4), reset asserted 2 cycles -> duty=0, busy=0, done=0, at_min=1, at_max=0.
load target=3 -> duty becomes 1, 2, 3 at 4, 8, 12 cycles after load; done for one cycle with duty=3; busy=0 after.
duty=3, load target=15 and hold enable=1 -> duty reaches 15 after 48 cycles, at_max=1, no wrap to 0 on later cycles.
ramping up at duty=8, load target=5 -> state DOWN, duty 7, 6, 5 at 4-cycle spacing, single done pulse.
duty=5, enable=0 for 20 cycles mid-ramp toward 10 -> duty frozen at 5; resumes with the remaining prescaler count; load target=duty -> done next cycle, busy stays 0.
rst asserted mid-ramp (duty=6) -> next cycle duty=0, state IDLE, no done. With DUTY_RAMP_BYPASS_EN, bypass=1 + load target=12 -> duty=12 next cycle, done the cycle after.
